// File: rtl/quad_enc_gen.sv
// Quadrature encoder pattern generator: emits a signed number of A/B edges at a fixed period and tracks position.
// Optional index pulse generation is enabled with `define QUAD_ENC_GEN_INDEX_EN.
module quad_enc_gen #(
  parameter int DIV_W = 16
) (
  input  logic                    clk_i,
  input  logic                    reset,
  input  logic                    start_wr,
  input  logic                    abort_i,
  input  logic signed [31:0]      step_cnt_i,
  input  logic        [DIV_W-1:0] period_i,
  input  logic                    pos_wr,
  input  logic        [31:0]      pos_i,
  input  logic        [31:0]      cpr_i,
  output logic                    quadA,
  output logic                    quadB,
  output logic                    index_strobe,
  output logic                    busy,
  output logic                    done,
  output logic signed [31:0]      position
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  state_t           state, state_nxt;
  logic             start_r1, start_r2, pos_r1, pos_r2;
  logic             start_edge, pos_edge;
  logic [31:0]      step_mag;
  logic [31:0]      remaining;
  logic [DIV_W-1:0] period_q, div_cnt;
  logic             dir_fwd;
  logic             edge_fire, last_edge, done_nxt;

  assign start_edge = start_r1 & ~start_r2;
  assign pos_edge   = pos_r1 & ~pos_r2;

  // Magnitude of the most negative count is 2^31, which still fits the unsigned counter.
  assign step_mag  = step_cnt_i[31] ? 32'(-step_cnt_i) : 32'(step_cnt_i);
  assign edge_fire = (state == RUN) && !abort_i && (div_cnt == period_q - DIV_ONE);
  assign last_edge = edge_fire && (remaining == 32'd1);
  assign busy      = (state == RUN);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          if (step_mag == 32'd0) done_nxt  = 1'b1;
          else                   state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (last_edge) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state     <= IDLE;
      start_r1  <= 1'b0;
      start_r2  <= 1'b0;
      pos_r1    <= 1'b0;
      pos_r2    <= 1'b0;
      remaining <= '0;
      period_q  <= DIV_ONE;
      div_cnt   <= '0;
      dir_fwd   <= 1'b1;
      quadA     <= 1'b0;
      quadB     <= 1'b0;
      done      <= 1'b0;
      position  <= '0;
    end else begin
      start_r1 <= start_wr;
      start_r2 <= start_r1;
      pos_r1   <= pos_wr;
      pos_r2   <= pos_r1;
      state    <= state_nxt;
      done     <= done_nxt;

      if (state == IDLE && start_edge) begin
        remaining <= step_mag;
        dir_fwd   <= ~step_cnt_i[31];
        period_q  <= (period_i == '0) ? DIV_ONE : period_i;
        div_cnt   <= '0;
      end else if (state == RUN) begin
        if (edge_fire) begin
          div_cnt   <= '0;
          remaining <= remaining - 32'd1;
        end else begin
          div_cnt <= div_cnt + DIV_ONE;
        end
      end

      // Forward walks AB 00->10->11->01, reverse walks the same ring backwards.
      if (edge_fire) begin
        if (dir_fwd) {quadA, quadB} <= {~quadB, quadA};
        else         {quadA, quadB} <= {quadB, ~quadA};
      end

      if (pos_edge)       position <= pos_i;
      else if (edge_fire) position <= dir_fwd ? position + 32'sd1 : position - 32'sd1;
    end
  end

`ifdef QUAD_ENC_GEN_INDEX_EN
  logic [31:0] rev_cnt, rev_nxt;

  always_comb begin
    rev_nxt = rev_cnt;
    if (dir_fwd) rev_nxt = (rev_cnt >= cpr_i - 32'd1) ? 32'd0 : rev_cnt + 32'd1;
    else         rev_nxt = (rev_cnt == 32'd0 || rev_cnt >= cpr_i) ? cpr_i - 32'd1 : rev_cnt - 32'd1;
  end

  // A position load also realigns the revolution, so it takes precedence over a coincident edge.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      rev_cnt      <= '0;
      index_strobe <= 1'b0;
    end else begin
      index_strobe <= 1'b0;
      if (pos_edge) begin
        rev_cnt <= '0;
      end else if (edge_fire && cpr_i != 32'd0) begin
        rev_cnt      <= rev_nxt;
        index_strobe <= (rev_nxt == 32'd0);
      end
    end
  end
`else
  logic unused_cpr;
  assign unused_cpr   = ^cpr_i;
  assign index_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_quad_enc_gen.sv
// Scoreboard bench for quad_enc_gen: each move pushes its expected edges (cycle, AB, position, index),
// and a per-cycle monitor pops and compares them as the DUT produces edges.
module tb_quad_enc_gen;
  localparam int DIV_W = 16;

  logic                    clk_i = 1'b0;
  logic                    reset, start_wr, abort_i, pos_wr;
  logic signed [31:0]      step_cnt_i;
  logic        [DIV_W-1:0] period_i;
  logic        [31:0]      pos_i, cpr_i;
  logic                    quadA, quadB, index_strobe, busy, done;
  logic signed [31:0]      position;

  quad_enc_gen #(.DIV_W(DIV_W)) dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .start_wr     (start_wr),
    .abort_i      (abort_i),
    .step_cnt_i   (step_cnt_i),
    .period_i     (period_i),
    .pos_wr       (pos_wr),
    .pos_i        (pos_i),
    .cpr_i        (cpr_i),
    .quadA        (quadA),
    .quadB        (quadB),
    .index_strobe (index_strobe),
    .busy         (busy),
    .done         (done),
    .position     (position)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  ab;
    logic [31:0] pos;
    logic        idx;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0, done_cyc = 0, busy_cnt = 0;
  int unsigned done0, busy0, exp_done_cyc, exp_busy;
  logic [1:0]  prev_ab = 2'b00;
  bit          mon_en = 1'b0;
  logic [1:0]  m_ab = 2'b00;
  logic [31:0] m_pos = 32'd0;
  logic [31:0] m_rev = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: sample at the falling edge and score any AB transition.
  task automatic tick();
    exp_t e;
    @(negedge clk_i);
    cyc++;
    if (mon_en) begin
      if ({quadA, quadB} !== prev_ab) begin
        if (exp_q.size() == 0) begin
          check("unexpected_edge", 32'({quadA, quadB}), 32'(prev_ab));
        end else begin
          e = exp_q.pop_front();
          check("edge_cycle", cyc, e.cyc);
          check("edge_ab", 32'({quadA, quadB}), 32'(e.ab));
          check("edge_pos", position, e.pos);
          check("edge_index", 32'(index_strobe), 32'(e.idx));
        end
      end else if (index_strobe) begin
        check("stray_index", 32'(index_strobe), 32'd0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
    end
    prev_ab = {quadA, quadB};
  endtask

  task automatic model_edge(input bit fwd, output logic idx);
    if (fwd) begin
      m_ab  = {~m_ab[0], m_ab[1]};
      m_pos = m_pos + 32'd1;
    end else begin
      m_ab  = {m_ab[0], ~m_ab[1]};
      m_pos = m_pos - 32'd1;
    end
    idx = 1'b0;
`ifdef QUAD_ENC_GEN_INDEX_EN
    if (cpr_i != 32'd0) begin
      if (fwd) m_rev = (m_rev + 32'd1 == cpr_i) ? 32'd0 : m_rev + 32'd1;
      else     m_rev = (m_rev == 32'd0) ? cpr_i - 32'd1 : m_rev - 32'd1;
      idx = (m_rev == 32'd0);
    end
`endif
  endtask

  // Drives a start pulse and pushes the first n_push expected edges; returns two cycles later (RUN entered).
  task automatic start_move(input int step, input int per, input int n_push);
    int unsigned p, n;
    logic        idx;
    exp_t        e;
    p = (per == 0) ? 1 : per;
    n = (step < 0) ? -step : step;
    step_cnt_i = step;
    period_i   = DIV_W'(per);
    start_wr   = 1'b1;
    for (int k = 1; k <= n_push; k++) begin
      model_edge(step > 0, idx);
      e.cyc = cyc + 2 + k * p;
      e.ab  = m_ab;
      e.pos = m_pos;
      e.idx = idx;
      exp_q.push_back(e);
    end
    exp_done_cyc = cyc + 2 + n * p;
    exp_busy     = n * p;
    done0        = done_cnt;
    busy0        = busy_cnt;
    tick();
    start_wr = 1'b0;
    tick();
  endtask

  task automatic wait_queue();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin
      tick();
      budget++;
    end
    check("edge_timeout", 32'(budget >= 3000), 32'd0);
  endtask

  task automatic finish_move();
    int budget = 0;
    while ((exp_q.size() != 0 || busy) && budget < 3000) begin
      tick();
      budget++;
    end
    check("move_timeout", 32'(budget >= 3000), 32'd0);
    repeat (3) tick();
    check("done_count", done_cnt - done0, 32'd1);
    check("done_cycle", done_cyc, exp_done_cyc);
    check("busy_cycles", busy_cnt - busy0, exp_busy);
    check("final_pos", position, m_pos);
    check("final_ab", 32'({quadA, quadB}), 32'(m_ab));
  endtask

  task automatic load_pos(input logic [31:0] v);
    pos_i  = v;
    pos_wr = 1'b1;
    tick();
    pos_wr = 1'b0;
    tick();
    check("pos_load", position, v);
    m_pos = v;
    m_rev = 32'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_wr = 1'b0; abort_i = 1'b0; pos_wr = 1'b0;
    step_cnt_i = '0; period_i = '0; pos_i = '0; cpr_i = '0;
    repeat (3) tick();
    check("rst_ab", 32'({quadA, quadB}), 32'd0);
    check("rst_index", 32'(index_strobe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pos", position, 32'd0);
    reset = 1'b0;
    tick();
    mon_en = 1'b1;

    // Forward 8 at period 4; start request and input changes mid-move must be ignored.
    start_move(8, 4, 8);
    step_cnt_i = -50;
    period_i   = DIV_W'(1);
    start_wr   = 1'b1;
    tick();
    start_wr = 1'b0;
    finish_move();

    // Reverse 3 at period 2 from position 0.
    load_pos(32'd0);
    start_move(-3, 2, 3);
    finish_move();

    // Null move, then period 0 behaving as period 1.
    start_move(0, 5, 0);
    finish_move();
    start_move(2, 0, 2);
    finish_move();

    // Abort after 10 of 100 edges: no done, outputs frozen.
    load_pos(32'd0);
    start_move(100, 3, 10);
    wait_queue();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    repeat (8) tick();
    check("abort_done", done_cnt - done0, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pos", position, 32'd10);
    check("abort_ab", 32'({quadA, quadB}), 32'(m_ab));

    // Index: cpr 4, forward 9 then reverse 5 continuing from the same revolution count.
    cpr_i = 32'd4;
    load_pos(32'd0);
    start_move(9, 1, 9);
    finish_move();
    start_move(-5, 2, 5);
    finish_move();
    cpr_i = 32'd0;

    // Reset in the middle of a 20-edge move.
    start_move(20, 2, 5);
    wait_queue();
    mon_en = 1'b0;
    reset  = 1'b1;
    tick();
    check("midrst_ab", 32'({quadA, quadB}), 32'd0);
    check("midrst_index", 32'(index_strobe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_pos", position, 32'd0);
    reset = 1'b0;
    m_ab  = 2'b00;
    m_pos = 32'd0;
    m_rev = 32'd0;
    tick();
    mon_en = 1'b1;
    repeat (6) tick();
    check("midrst_no_done", done_cnt - done0, 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    // Position wrap from the largest positive value.
    load_pos(32'h7FFF_FFFF);
    start_move(1, 1, 1);
    finish_move();
    check("pos_wrap", position, 32'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/quad_enc_gen.md
QUAD_ENC_GEN -- requirements
Module: quad_enc_gen

Interface
REQ-001 SHALL have parameter: DIV_W, 16, width of edge-period input.
REQ-002 SHALL have port: clk_i  in  1  single clock; all logic on posedge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: start_wr  in  1  start request; acted on at its rising edge.
REQ-005 SHALL have port: abort_i  in  1  level; stops a running move.
REQ-006 SHALL have port: step_cnt_i  in  32  signed edge count; sign gives direction.
REQ-007 SHALL have port: period_i  in  DIV_W  clk_i cycles per quadrature edge.
REQ-008 SHALL have port: pos_wr  in  1  position load; acted on at its rising edge.
REQ-009 SHALL have port: pos_i  in  32  position load value.
REQ-010 SHALL have port: cpr_i  in  32  edges per revolution, for index generation.
REQ-011 SHALL have port: quadA, quadB  out  1 each  quadrature outputs.
REQ-012 SHALL have port: index_strobe  out  1  index pulse.
REQ-013 SHALL have port: busy  out  1  high in RUN.
REQ-014 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-015 SHALL have port: position  out  32  signed emitted-edge count.

Function
REQ-016 SHALL detect rising edges of start_wr and pos_wr via two-flop register pair (reg1 & ~reg2); level inputs are ignored after the edge.
REQ-017 SHALL implement FSM IDLE -> RUN -> IDLE; start edge in IDLE latches |step_cnt_i|, sign and max(period_i,1), enters RUN next cycle.
REQ-018 SHALL treat step_cnt_i == 0 as a null move: no edges, done pulses one cycle after start edge, busy stays low.
REQ-019 SHALL ignore start edges while in RUN.
REQ-020 SHALL emit first edge exactly P cycles after entering RUN and each following edge every P cycles (P = latched period).
REQ-021 SHALL sequence (quadA,quadB) forward (step_cnt_i > 0) as 00,10,11,01,00 and reverse as 00,01,11,10,00, one transition per edge.
REQ-022 SHALL increment position on forward edge, decrement on reverse edge, 32-bit two's-complement wrap.
REQ-023 SHALL, on final edge, return to IDLE next cycle with done high one cycle, busy low same cycle.
REQ-024 SHALL, on abort_i high in RUN, return to IDLE next cycle without done and without further edges; quadA/quadB/position hold.
REQ-025 SHALL, on pos_wr edge, load position from pos_i; if an edge occurs same cycle, load wins and edge is not counted.
REQ-026 SHALL hold quadA/quadB phase across moves; a new move continues from current phase.
REQ-027 SHALL keep period_i and step_cnt_i changes during RUN without effect until next start.

Reset
REQ-028 SHALL, when reset high at posedge, force: state IDLE, quadA=0, quadB=0, index_strobe=0, busy=0, done=0, position=0, edge-detect flops 0, divider 0, revolution counter 0.
REQ-029 SHALL abandon any move on reset mid-RUN with no done pulse; outputs take reset values next cycle.

Configuration
REQ-030 SHALL gate index generation with macro QUAD_ENC_GEN_INDEX_EN.
REQ-031 SHALL, with QUAD_ENC_GEN_INDEX_EN defined, keep revolution counter 0..cpr_i-1: +1 on forward edge wrapping cpr_i-1->0, -1 on reverse wrapping 0->cpr_i-1; index_strobe high exactly one cycle, coincident with the quad edge landing on 0; cpr_i==0 disables index; pos_wr clears revolution counter.
REQ-032 SHALL, without QUAD_ENC_GEN_INDEX_EN, tie index_strobe to 0, ignore cpr_i, and contain no revolution counter.

Verification
REQ-033 SHALL cover: step_cnt_i=8, period_i=4 -> AB 00,10,11,01,00,10,11,01,00 at 4-cycle spacing, position=8, one done pulse, busy high 32 cycles.
REQ-034 SHALL cover: step_cnt_i=-3, period_i=2 -> AB 00,01,11,10, position=-3, done once.
REQ-035 SHALL cover: step_cnt_i=100, period_i=3, abort_i raised after 10 edges -> position=10, no done, AB frozen.
REQ-036 SHALL cover: step_cnt_i=0 and period_i=0 with step_cnt_i=2 -> null move gives done with no edges; period 0 gives edges every 1 cycle.
REQ-037 SHALL cover (index on): cpr_i=4, step_cnt_i=9 -> index_strobe single-cycle pulses at edges 4 and 8; repeat with step_cnt_i=-5 -> pulses at edges 1 and 5 going reverse from 0.
REQ-038 SHALL cover: reset asserted mid-move (step_cnt_i=20, after 5 edges) -> all outputs zero next cycle, no done; pos_wr with pos_i=0x7FFFFFFF then step_cnt_i=1 -> position=0x80000000.
